ibex_counter_unit: RTL and testbench



---
 rtl/ibex_counter_unit.sv | 132 +++++++++++++
 tb/tb_ibex_counter_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_counter_unit.sv
// rtl/ibex_counter_unit.sv - event counter bank with a stall-aware register-file write-back port
module ibex_counter_unit #(
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned CounterWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumCounters-1:0] cnt_event_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [3:0]             req_idx_i,
  input  logic [31:0]            req_wdata_i,
  input  logic [4:0]             req_rd_i,
  input  logic                   rf_busy_i,
  output logic                   rf_we_counter_unit_o,
  output logic [31:0]            rf_wdata_counter_unit_o,
  output logic [4:0]             rf_waddr_counter_unit_o,
  output logic [NumCounters-1:0] overflow_o,
  output logic                   busy_o
);

  localparam logic [1:0] OpRead      = 2'b00;
  localparam logic [1:0] OpWrite     = 2'b01;
  localparam logic [1:0] OpClear     = 2'b10;
  localparam logic [1:0] OpReadClear = 2'b11;

  typedef enum logic {
    StIdle,
    StPend
  } state_e;

  state_e                  state_q, state_d;
  logic [CounterWidth-1:0] cnt_q [NumCounters];
  logic [NumCounters-1:0]  ovf_q;
  logic [31:0]             result_q;
  logic [4:0]              addr_q;

  logic                    req_accept;
  logic                    idx_in_range;
  logic                    op_is_read;
  logic                    op_loads_cnt;
  logic [CounterWidth-1:0] load_value;
  logic [31:0]             read_value;

  assign req_accept   = req_valid_i & req_ready_o;
  assign idx_in_range = ({28'd0, req_idx_i} < NumCounters);
  assign op_is_read   = (req_op_i == OpRead) | (req_op_i == OpReadClear);
  // WRITE, CLEAR and READ_CLEAR all overwrite the counter and drop its overflow flag.
  assign op_loads_cnt = (req_op_i == OpWrite) | (req_op_i == OpClear) |
                        (req_op_i == OpReadClear);
  assign load_value   = (req_op_i == OpWrite) ? req_wdata_i[CounterWidth-1:0] : '0;

  // Select the addressed counter's current (pre-update) value, zero-extended; 0 when out of range.
  always_comb begin
    read_value = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (idx_in_range && (req_idx_i == 4'(i))) begin
        read_value[CounterWidth-1:0] = cnt_q[i];
      end
    end
  end

  // Counter bank: a request on counter i takes priority over that counter's event this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCounters; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NumCounters; i++) begin
        if (req_accept && idx_in_range && (req_idx_i == 4'(i)) && op_loads_cnt) begin
          cnt_q[i] <= load_value;
          ovf_q[i] <= 1'b0;
        end else if (cnt_event_i[i]) begin
          cnt_q[i] <= cnt_q[i] + CounterWidth'(1);
          if (&cnt_q[i]) begin
            ovf_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Next state: a read to a non-zero rd waits in PEND until the RF write port is free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_accept && op_is_read && (req_rd_i != 5'd0)) begin
          state_d = StPend;
        end
      end
      StPend: begin
        if (!rf_busy_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; async reset drops PEND so the write strobe falls immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture read result and destination on every accepted READ / READ_CLEAR; held stable while pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
      addr_q   <= '0;
    end else if (req_accept && op_is_read) begin
      result_q <= read_value;
      addr_q   <= req_rd_i;
    end
  end

  assign req_ready_o             = (state_q == StIdle);
  assign busy_o                  = (state_q == StPend);
  // Only write when neither ID/EX nor LSU owns the RF port, keeping write sources one-hot.
  assign rf_we_counter_unit_o    = (state_q == StPend) & ~rf_busy_i;
  assign rf_wdata_counter_unit_o = result_q;
  assign rf_waddr_counter_unit_o = addr_q;
  assign overflow_o              = ovf_q;

endmodule

// File: tb/tb_ibex_counter_unit.sv
// tb/tb_ibex_counter_unit.sv - directed self-checking bench for ibex_counter_unit
module tb_ibex_counter_unit;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] cnt_event = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [3:0]    req_idx = 4'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic [4:0]    req_rd = 5'd0;
  logic          rf_busy = 1'b0;
  logic          rf_we;
  logic [31:0]   rf_wdata;
  logic [4:0]    rf_waddr;
  logic [NC-1:0] overflow;
  logic          busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit checking = 1'b0;

  ibex_counter_unit #(.NumCounters(NC), .CounterWidth(32)) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .cnt_event_i             (cnt_event),
    .req_valid_i             (req_valid),
    .req_ready_o             (req_ready),
    .req_op_i                (req_op),
    .req_idx_i               (req_idx),
    .req_wdata_i             (req_wdata),
    .req_rd_i                (req_rd),
    .rf_busy_i               (rf_busy),
    .rf_we_counter_unit_o    (rf_we),
    .rf_wdata_counter_unit_o (rf_wdata),
    .rf_waddr_counter_unit_o (rf_waddr),
    .overflow_o              (overflow),
    .busy_o                  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: counts as integers, a pending flag and the value/address owed to the RF.
  int unsigned m_cnt [NC];
  bit          m_ovf [NC];
  bit          m_pend = 1'b0;
  int unsigned m_res = 0;
  int unsigned m_addr = 0;

  always @(posedge clk or negedge rst_n) begin
    int unsigned old_cnt [NC];
    bit          acc;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_ovf[i] = 1'b0; end
      m_pend = 1'b0;
    end else begin
      old_cnt = m_cnt;
      acc = req_valid && !m_pend;
      if (m_pend && !rf_busy) m_pend = 1'b0;
      for (int i = 0; i < NC; i++) begin
        if (acc && req_op != 2'b00 && int'(req_idx) == i) begin
          m_cnt[i] = (req_op == 2'b01) ? req_wdata : 0;
          m_ovf[i] = 1'b0;
        end else if (cnt_event[i]) begin
          if (m_cnt[i] == 32'hFFFF_FFFF) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      if (acc && (req_op == 2'b00 || req_op == 2'b11)) begin
        m_res  = (int'(req_idx) < NC) ? old_cnt[req_idx] : 0;
        m_addr = req_rd;
        if (req_rd != 0) m_pend = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [NC-1:0] exp_ovf;
    bit exp_we;
    if (checking) begin
      for (int i = 0; i < NC; i++) exp_ovf[i] = m_ovf[i];
      exp_we = m_pend && !rf_busy && rst_n;
      chk("cyc_req_ready", 32'(req_ready), 32'(!m_pend));
      chk("cyc_busy", 32'(busy), 32'(m_pend));
      chk("cyc_rf_we", 32'(rf_we), 32'(exp_we));
      chk("cyc_overflow", 32'(overflow), 32'(exp_ovf));
      chk("cyc_we_and_rfbusy", 32'(rf_we & rf_busy), 32'd0);
      if (exp_we) begin
        chk("cyc_wdata", rf_wdata, m_res);
        chk("cyc_waddr", 32'(rf_waddr), m_addr);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] idx, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [NC-1:0] ev);
    int n = 0;
    while (!req_ready && n < 20) begin cyc(); n++; end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1; req_op = op; req_idx = idx; req_wdata = wd; req_rd = rd; cnt_event = ev;
    cyc();
    req_valid = 1'b0; cnt_event = '0;
  endtask

  task automatic expect_write(input string name, input logic [4:0] addr, input logic [31:0] data);
    #1;
    chk({name, "_we"}, 32'(rf_we), 32'd1);
    chk({name, "_waddr"}, 32'(rf_waddr), 32'(addr));
    chk({name, "_wdata"}, rf_wdata, data);
  endtask

  initial begin
    repeat (2) cyc();
    checking = 1'b1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Counting and READ
    cnt_event = 4'b0010;
    repeat (5) cyc();
    cnt_event = '0;
    issue(2'b00, 4'd1, 32'd0, 5'd7, '0);
    expect_write("read1", 5'd7, 32'd5);
    cyc();
    chk("read1_single_cycle", 32'(rf_we), 32'd0);

    // READ with a same-cycle event: old value returned, counter still increments
    issue(2'b00, 4'd1, 32'd0, 5'd5, 4'b0010);
    expect_write("read_ev", 5'd5, 32'd5);
    cyc();
    issue(2'b00, 4'd1, 32'd0, 5'd5, '0);
    expect_write("read_ev_after", 5'd5, 32'd6);
    cyc();

    // Write-port stall
    issue(2'b01, 4'd0, 32'd3, 5'd0, '0);
    rf_busy = 1'b1;
    issue(2'b00, 4'd0, 32'd0, 5'd4, '0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_we", 32'(rf_we), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    rf_busy = 1'b0;
    expect_write("stall_release", 5'd4, 32'd3);
    cyc();

    // Wrap and overflow
    issue(2'b01, 4'd2, 32'hFFFF_FFFF, 5'd0, '0);
    cnt_event = 4'b0100;
    cyc();
    cnt_event = '0;
    chk("wrap_ovf", 32'(overflow[2]), 32'd1);
    issue(2'b00, 4'd2, 32'd0, 5'd3, '0);
    expect_write("wrap_read", 5'd3, 32'd0);
    cyc();
    issue(2'b10, 4'd2, 32'd0, 5'd0, '0);
    chk("clear_ovf", 32'(overflow[2]), 32'd0);

    // READ_CLEAR with a same-cycle event
    issue(2'b01, 4'd3, 32'd10, 5'd0, '0);
    issue(2'b11, 4'd3, 32'd0, 5'd9, 4'b1000);
    expect_write("rdclr", 5'd9, 32'd10);
    cyc();
    issue(2'b00, 4'd3, 32'd0, 5'd9, '0);
    expect_write("rdclr_after", 5'd9, 32'd0);
    cyc();

    // Out-of-range index and rd = 0
    issue(2'b01, 4'd5, 32'd77, 5'd0, '0);
    issue(2'b00, 4'd5, 32'd0, 5'd2, '0);
    expect_write("oor_read", 5'd2, 32'd0);
    cyc();
    issue(2'b00, 4'd0, 32'd0, 5'd0, '0);
    #1;
    chk("rd0_no_we", 32'(rf_we), 32'd0);
    chk("rd0_ready", 32'(req_ready), 32'd1);
    cyc();

    // Reset mid-PEND
    rf_busy = 1'b1;
    issue(2'b00, 4'd1, 32'd0, 5'd7, '0);
    cyc();
    rf_busy = 1'b0;
    #1;
    chk("pre_rst_we", 32'(rf_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(rf_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_wdata", rf_wdata, 32'd0);
    chk("midrst_waddr", 32'(rf_waddr), 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("post_rst_no_we", 32'(rf_we), 32'd0);
    end

    checking = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
